imem_loader: RTL and testbench

- Byte-serial program loader for the beaver32rv single-cycle core.
- Receives a length-prefixed stream of little-endian 32-bit instruction words and writes them into instruction memory.
- Holds the core in reset during loading and releases it once the last word is written.
- Writes into the core from outside (preload and boot) rather than observing it. It replaces hard-coded memory init when tests boot the core.

---
 rtl/imem_loader_if.sv | 28 ++
 rtl/imem_loader.sv | 135 +++++++++++++
 tb/tb_imem_loader.sv | 280 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_if.sv
// Purpose: bundles the byte-stream handshake, imem write port and core control of imem_loader.
// Latency: none; this is wiring only.
// Backpressure: in_ready (slave to master) gates in_valid/in_data transfers.
//   master: stream source / observer (drives in_valid, in_data)
//   slave : loader (drives in_ready, imem_*, core_rst, done, err)
interface imem_loader_if #(
    parameter int ADDR_W = 32
);
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              imem_we;
    logic [ADDR_W-1:0] imem_waddr;
    logic [31:0]       imem_wdata;
    logic              core_rst;
    logic              done;
    logic              err;

    modport master (
        output in_valid, in_data,
        input  in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err
    );

    modport slave (
        input  in_valid, in_data,
        output in_ready, imem_we, imem_waddr, imem_wdata, core_rst, done, err
    );
endinterface

// File: rtl/imem_loader.sv
// Purpose: loads a length-prefixed little-endian word stream into imem, holding the core in reset until done.
// Latency: 4th byte accepted at edge k -> imem_we for one cycle after k -> core released after edge k+1.
// Backpressure: in_ready is 0 during the WRITE bubble and in RUN/ERR; a byte moves on in_valid && in_ready.
//   Ports: clk, rst (sync, active high); bus.slave carries in_valid/in_data/in_ready,
//   imem_we/imem_waddr/imem_wdata, core_rst, done, err.
module imem_loader #(
    parameter int DEPTH_WORDS = 256,
    parameter int ADDR_W      = 32
) (
    input  logic        clk,
    input  logic        rst,
    imem_loader_if.slave bus
);
    typedef enum logic [2:0] {LEN_LO, LEN_HI, DATA, WRITE, RUN, ERR} state_t;

    localparam logic [16:0] DEPTH_L = 17'(DEPTH_WORDS);

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [15:0]       word_idx_q, word_idx_d;
    logic [15:0]       len_q, len_d;
    logic [31:0]       shift_q, shift_d;
    logic              in_ready_q, in_ready_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic              core_rst_q, core_rst_d;
    logic              done_q, done_d;
    logic              err_q, err_d;

    logic              xfer;
    logic [15:0]       len_new;
    logic [15:0]       word_idx_inc;

    assign xfer         = bus.in_valid && in_ready_q;
    assign len_new      = {bus.in_data, len_q[7:0]};
    assign word_idx_inc = word_idx_q + 16'd1;

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        word_idx_d = word_idx_q;
        len_d      = len_q;
        shift_d    = shift_q;
        waddr_d    = waddr_q;
        wdata_d    = wdata_q;

        case (state_q)
            LEN_LO: begin
                if (xfer) begin
                    len_d[7:0] = bus.in_data;
                    state_d    = LEN_HI;
                end
            end
            LEN_HI: begin
                if (xfer) begin
                    len_d[15:8] = bus.in_data;
                    if (len_new == 16'd0) begin
                        state_d = RUN;
                    end else if ({1'b0, len_new} > DEPTH_L) begin
                        state_d = ERR;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (xfer) begin
                    shift_d[{byte_cnt_q, 3'b000} +: 8] = bus.in_data;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Address/data are captured here so they are valid
                        // exactly in the WRITE cycle that follows.
                        state_d = WRITE;
                        waddr_d = ADDR_W'({word_idx_q, 2'b00});
                        wdata_d = shift_d;
                    end
                end
            end
            WRITE: begin
                word_idx_d = word_idx_inc;
                state_d    = (word_idx_inc == len_q) ? RUN : DATA;
            end
            default: begin
                // RUN and ERR are terminal until rst.
                state_d = state_q;
            end
        endcase

        // Outputs decoded from the next state so they line up with state_q.
        in_ready_d = (state_d == LEN_LO) || (state_d == LEN_HI) || (state_d == DATA);
        we_d       = (state_d == WRITE);
        core_rst_d = (state_d != RUN);
        done_d     = (state_d == RUN);
        err_d      = (state_d == ERR);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= LEN_LO;
            byte_cnt_q <= 2'd0;
            word_idx_q <= 16'd0;
            len_q      <= 16'd0;
            shift_q    <= 32'd0;
            in_ready_q <= 1'b1;
            we_q       <= 1'b0;
            waddr_q    <= '0;
            wdata_q    <= 32'd0;
            core_rst_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            word_idx_q <= word_idx_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            in_ready_q <= in_ready_d;
            we_q       <= we_d;
            waddr_q    <= waddr_d;
            wdata_q    <= wdata_d;
            core_rst_q <= core_rst_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = we_q;
    assign bus.imem_waddr = waddr_q;
    assign bus.imem_wdata = wdata_q;
    assign bus.core_rst   = core_rst_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;
endmodule

// File: tb/tb_imem_loader.sv
// Purpose: self-checking bench for imem_loader (directed table, hand sequences, random vs model).
// Latency: n/a.
// Backpressure: source holds each byte until in_ready has been seen high at a transfer edge.
module tb_imem_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    imem_loader_if #(.ADDR_W(32)) bus ();

    imem_loader #(.DEPTH_WORDS(256), .ADDR_W(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    logic [31:0] got_addr[$];
    logic [31:0] got_data[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    logic [7:0]  stim[$];
    bit          exp_done;
    bit          exp_err;

    typedef struct {
        int          n;
        logic [79:0] bytes;   // first stream byte in bits 79:72
        int          gap;
        int          nw;
        bit          done;
        bit          err;
        logic [31:0] laddr;
        logic [31:0] ldata;
    } vec_t;

    vec_t tbl[6];

    // Write scoreboard: every strobe observed away from the active edge.
    always @(negedge clk) begin
        if (bus.imem_we) begin
            got_addr.push_back(bus.imem_waddr);
            got_data.push_back(bus.imem_wdata);
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic do_reset();
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        got_addr.delete();
        got_data.delete();
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        bit ok;
        ok = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        for (int n = 0; n < 40 && !ok; n++) begin
            @(negedge clk);
            ok = bus.in_ready;
        end
        if (!ok) begin
            checks++;
            failures++;
            $display("FAIL send_byte: in_ready stayed %0b, want 1 (byte %0h)", bus.in_ready, b);
            bus.in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 bus.in_valid = 1'b0;
        end
    endtask

    task automatic play(input int gapmax, input bit rnd);
        foreach (stim[i]) send_byte(stim[i], rnd ? int'($urandom_range(0, gapmax)) : gapmax);
    endtask

    // Reference: parse the whole stream as the loader format defines it.
    task automatic build_model();
        logic [15:0] len;
        exp_addr.delete();
        exp_data.delete();
        len      = {stim[1], stim[0]};
        exp_err  = (len > 16'd256);
        exp_done = !exp_err;
        if (!exp_err) begin
            for (int i = 0; i < int'(len); i++) begin
                exp_addr.push_back(32'(i * 4));
                exp_data.push_back({stim[2+4*i+3], stim[2+4*i+2], stim[2+4*i+1], stim[2+4*i]});
            end
        end
    endtask

    task automatic compare_model(input string tag);
        int n;
        build_model();
        repeat (3) @(negedge clk);
        chk({tag, " nwr"}, got_addr.size(), exp_addr.size());
        n = (got_addr.size() < exp_addr.size()) ? got_addr.size() : exp_addr.size();
        for (int i = 0; i < n; i++) begin
            chk($sformatf("%s addr[%0d]", tag, i), got_addr[i], exp_addr[i]);
            chk($sformatf("%s data[%0d]", tag, i), got_data[i], exp_data[i]);
        end
        chk({tag, " done"}, bus.done, exp_done);
        chk({tag, " err"}, bus.err, exp_err);
        chk({tag, " core_rst"}, bus.core_rst, !exp_done);
        chk({tag, " in_ready"}, bus.in_ready, 1'b0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation still running, want finished");
        $fatal(1, "timeout");
    end

    initial begin
        bit bad;
        int len;

        tbl[0] = '{6,  80'h0100_1305_5000_0000_0000, 0, 1, 1'b1, 1'b0, 32'h0, 32'h00500513};
        tbl[1] = '{10, 80'h0200_1122_3344_5566_7788, 1, 2, 1'b1, 1'b0, 32'h4, 32'h88776655};
        tbl[2] = '{2,  80'h0000_0000_0000_0000_0000, 0, 0, 1'b1, 1'b0, 32'h0, 32'h0};
        tbl[3] = '{2,  80'h0101_0000_0000_0000_0000, 0, 0, 1'b0, 1'b1, 32'h0, 32'h0};
        tbl[4] = '{2,  80'hFFFF_0000_0000_0000_0000, 1, 0, 1'b0, 1'b1, 32'h0, 32'h0};
        tbl[5] = '{6,  80'h0100_EFBE_ADDE_0000_0000, 2, 1, 1'b1, 1'b0, 32'h0, 32'hDEADBEEF};

        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;

        // Reset state.
        do_reset();
        @(negedge clk);
        chk("rst in_ready", bus.in_ready, 1'b1);
        chk("rst we", bus.imem_we, 1'b0);
        chk("rst waddr", bus.imem_waddr, 32'h0);
        chk("rst wdata", bus.imem_wdata, 32'h0);
        chk("rst core_rst", bus.core_rst, 1'b1);
        chk("rst done", bus.done, 1'b0);
        chk("rst err", bus.err, 1'b0);

        // Directed table.
        for (int i = 0; i < 6; i++) begin
            do_reset();
            stim.delete();
            for (int j = 0; j < tbl[i].n; j++) stim.push_back(tbl[i].bytes[79-8*j -: 8]);
            play(tbl[i].gap, 1'b0);
            repeat (3) @(negedge clk);
            chk($sformatf("tbl%0d nwr", i), got_addr.size(), tbl[i].nw);
            if (tbl[i].nw > 0 && got_addr.size() == tbl[i].nw) begin
                chk($sformatf("tbl%0d laddr", i), got_addr[tbl[i].nw-1], tbl[i].laddr);
                chk($sformatf("tbl%0d ldata", i), got_data[tbl[i].nw-1], tbl[i].ldata);
            end
            chk($sformatf("tbl%0d done", i), bus.done, tbl[i].done);
            chk($sformatf("tbl%0d err", i), bus.err, tbl[i].err);
            chk($sformatf("tbl%0d core_rst", i), bus.core_rst, !tbl[i].done);
        end

        // Latency: strobe in the cycle after the 4th byte, release one edge later.
        do_reset();
        send_byte(8'h01, 0); send_byte(8'h00, 0);
        send_byte(8'h13, 0); send_byte(8'h05, 0); send_byte(8'h50, 0); send_byte(8'h00, 0);
        chk("lat we", bus.imem_we, 1'b1);
        chk("lat waddr", bus.imem_waddr, 32'h0);
        chk("lat wdata", bus.imem_wdata, 32'h00500513);
        chk("lat in_ready", bus.in_ready, 1'b0);
        chk("lat core_rst_held", bus.core_rst, 1'b1);
        @(posedge clk); #1;
        chk("lat we_off", bus.imem_we, 1'b0);
        chk("lat done", bus.done, 1'b1);
        chk("lat core_rst", bus.core_rst, 1'b0);

        // Empty program releases the core straight from LEN_HI.
        do_reset();
        send_byte(8'h00, 0); send_byte(8'h00, 0);
        chk("empty done", bus.done, 1'b1);
        chk("empty core_rst", bus.core_rst, 1'b0);
        repeat (2) @(negedge clk);
        chk("empty nwr", got_addr.size(), 0);

        // Oversize length: ERR, then 20 offered bytes must be refused.
        do_reset();
        send_byte(8'h01, 0); send_byte(8'h01, 0);
        chk("err err", bus.err, 1'b1);
        chk("err in_ready", bus.in_ready, 1'b0);
        bad = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 20; i++) begin
            bus.in_data = 8'($urandom);
            @(negedge clk);
            if (bus.in_ready || bus.imem_we || !bus.core_rst) bad = 1'b1;
            @(posedge clk); #1;
        end
        bus.in_valid = 1'b0;
        chk("err refuse_20", bad, 1'b0);
        chk("err nwr", got_addr.size(), 0);
        chk("err still", bus.err, 1'b1);

        // Reset mid-word: byte lane must restart at 0.
        do_reset();
        send_byte(8'h02, 0); send_byte(8'h00, 0);
        for (int i = 0; i < 6; i++) send_byte(8'(8'h30 + i), 0);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        chk("mid rst in_ready", bus.in_ready, 1'b1);
        chk("mid rst core_rst", bus.core_rst, 1'b1);
        got_addr.delete();
        got_data.delete();
        stim = '{8'h01, 8'h00, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        play(0, 1'b0);
        compare_model("mid");

        // Random streams against the model.
        for (int t = 0; t < 30; t++) begin
            do_reset();
            stim.delete();
            case ($urandom_range(0, 9))
                0:       len = 0;
                1:       len = 257 + int'($urandom_range(0, 60000));
                default: len = int'($urandom_range(1, 6));
            endcase
            stim.push_back(8'(len));
            stim.push_back(8'(len >> 8));
            if (len <= 256)
                for (int j = 0; j < 4 * len; j++) stim.push_back(8'($urandom));
            play(2, 1'b1);
            compare_model($sformatf("rnd%0d", t));
        end

        // Full depth: word i = i, last address 0x3FC.
        do_reset();
        stim.delete();
        stim.push_back(8'h00);
        stim.push_back(8'h01);
        for (int i = 0; i < 256; i++) begin
            stim.push_back(8'(i)); stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h00);
        end
        play(0, 1'b0);
        compare_model("full");
        if (got_addr.size() == 256) begin
            chk("full last waddr", got_addr[255], 32'h3FC);
            chk("full last wdata", got_data[255], 32'hFF);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 8'hAA;
        bad = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (bus.in_ready || bus.imem_we) bad = 1'b1;
        end
        bus.in_valid = 1'b0;
        chk("full extra ignored", bad, 1'b0);
        chk("full nwr after extra", got_addr.size(), 256);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1;
        chk("run rst core_rst", bus.core_rst, 1'b1);
        chk("run rst done", bus.done, 1'b0);
        chk("run rst in_ready", bus.in_ready, 1'b1);
        rst = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
